window_apply_sequencer: RTL and testbench
=========================================

// Module: window_apply_sequencer
// PURPOSE
//  Initiator/consumer for the window function generator. Per frame of N=2^lgn samples it
//  steps index i=0..N-1, triggers the generator (en/busy), captures the Q8 coefficient
//  (256 = 1.0), multiplies it with the incoming sample stream and emits windowed samples.
//  It sits between the ADC/mixer sample stream and the LIA demodulation/FFT path.
// PARAMETERS
//  EN_HOLD   2     cycles gen_en is held high per request (>=2; generator 2-flop edge detect)
//  TIMEOUT   64    max cycles waiting for gen_busy rise or fall before error (timeout build)
//  DW        16    sample / output width (signed)
// PORTS
//  clk           in   1   clock
//  rst_n         in   1   asynchronous active-low reset
//  start         in   1   pulse: begin frame (ignored unless IDLE)
//  abort         in   1   sync: drop current frame, return to IDLE next cycle
//  win_type_in   in   4   window type, latched at start (1 rect,3 tri,4 Hann,5 Hamming,6 Blackman)
//  lgn_in        in   8   log2 frame length, latched at start; legal 1..15
//  s_valid       in   1   input sample valid
//  s_ready       out  1   input sample accepted when s_valid&s_ready
//  s_data        in   DW  signed input sample
//  m_valid       out  1   windowed sample valid; held until m_ready
//  m_ready       in   1   downstream ready
//  m_data        out  DW  signed windowed sample
//  m_last        out  1   high with m_valid on index N-1
//  gen_en        out  1   generator trigger
//  gen_win_type  out  4   latched win_type to generator
//  gen_n         out  16  1<<lgn to generator
//  gen_lgn       out  8   latched lgn to generator
//  gen_i         out  16  current index to generator
//  gen_busy      in   1   generator busy
//  gen_win       in   16  signed Q8 coefficient from generator
//  busy          out  1   high in every state except IDLE
//  frame_done    out  1   one-cycle pulse after last output handshake
//  err           out  1   sticky generator timeout flag; cleared by start or reset
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; gen_i=0; latched type/lgn=0.
//  States: IDLE -start-> EN_HI (gen_en=1, EN_HOLD cycles) -> WAIT_RISE (gen_en=0, until
//   gen_busy=1) -> WAIT_FALL (until gen_busy=0; capture gen_win into coef that cycle)
//   -> GET_S (s_ready=1 until s_valid) -> MUL (1 cycle) -> OUT (m_valid=1 until m_ready)
//   -> if gen_i==N-1: DONE (frame_done=1, 1 cycle) -> IDLE; else gen_i+=1, EN_HI.
//  gen_en always low >=1 cycle between requests (guaranteed by WAIT_RISE/FALL path).
//  Arithmetic: prod = s_data*coef (32b signed); m_data = prod>>>8 saturated to
//   [-32768,32767]. Latency coef capture -> m_valid: 1 cycle after sample accept.
//  m_data/m_valid/m_last stable while m_valid&!m_ready. s_ready low outside GET_S.
//  start while busy: ignored. start same cycle as abort in IDLE: abort wins (stay IDLE).
//  abort any state: next cycle IDLE, gen_en=0, m_valid=0, gen_i=0, no frame_done.
//  lgn_in 0 or >15 at start: clamp to 15? No -- treated as illegal: err=1, stay IDLE.
//  Async reset mid-frame: immediate return to reset values; no partial frame_done.
// CONFIGURATION
//  WINSEQ_TIMEOUT_EN defined: a TIMEOUT counter runs in WAIT_RISE and WAIT_FALL; on
//   expiry err=1, frame aborted (IDLE, no frame_done). Counter resets on each state entry.
//  Not defined: no counter; sequencer waits indefinitely; err set only by illegal lgn.
// TESTING
//  rect(1), lgn=2, s_data=1000 x4 -> m_data=1000 x4, m_last on 4th, frame_done 1 pulse.
//  Hann(4), lgn=3, s_data=20000 -> i=0 output 0; i=4 output ~=20000 (coef 256).
//  Extremes: coef=256, s_data=-32768 -> -32768; s_data=32767 -> 32767; no wrap.
//  Backpressure: m_ready low 5 cycles at i=1 -> m_data stable, gen_en not reasserted.
//  TIMEOUT_EN, gen_busy tied 0 -> err=1 after TIMEOUT cycles in WAIT_RISE, state IDLE.
//  abort at i=2 then start -> new frame from i=0, no stale m_valid, err cleared.

Source files
------------

// File: rtl/window_apply_sequencer_if.sv
// rtl/window_apply_sequencer_if.sv - sample stream, windowed output stream and generator request bundle
interface window_apply_sequencer_if #(
  parameter int DW = 16
);
  logic                 s_valid;
  logic                 s_ready;
  logic signed [DW-1:0] s_data;
  logic                 m_valid;
  logic                 m_ready;
  logic signed [DW-1:0] m_data;
  logic                 m_last;
  logic                 gen_en;
  logic [3:0]           gen_win_type;
  logic [15:0]          gen_n;
  logic [7:0]           gen_lgn;
  logic [15:0]          gen_i;
  logic                 gen_busy;
  logic signed [15:0]   gen_win;

  modport master (
    input  s_valid, s_data, m_ready, gen_busy, gen_win,
    output s_ready, m_valid, m_data, m_last, gen_en, gen_win_type, gen_n, gen_lgn, gen_i
  );

  modport slave (
    output s_valid, s_data, m_ready, gen_busy, gen_win,
    input  s_ready, m_valid, m_data, m_last, gen_en, gen_win_type, gen_n, gen_lgn, gen_i
  );
endinterface

// File: rtl/window_apply_sequencer.sv
// rtl/window_apply_sequencer.sv - per-frame window coefficient fetch and sample multiply sequencer
// Optional generator timeout watchdog enabled by WINSEQ_TIMEOUT_EN.
module window_apply_sequencer #(
  parameter int EN_HOLD = 2,
  parameter int TIMEOUT = 64,
  parameter int DW      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [3:0]              win_type_in,
  input  logic [7:0]              lgn_in,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    err,
  window_apply_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, EN_HI, WAIT_RISE, WAIT_FALL, GET_S, MUL, OUT, DONE
  } state_t;

  localparam int CNT_MAX = (EN_HOLD > TIMEOUT) ? EN_HOLD : TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic signed [2*DW-1:0] PMAX = {{(DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [2*DW-1:0] PMIN = ~PMAX;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt;
  logic [15:0]          gen_i_q;
  logic [3:0]           type_q;
  logic [7:0]           lgn_q;
  logic signed [15:0]   coef;
  logic signed [DW-1:0] s_q;
  logic signed [DW-1:0] m_data_q;
  logic signed [2*DW-1:0] prod, shr;
  logic signed [DW-1:0] sat;
  logic                 lgn_ok, last, to_hit, counting;
  logic [15:0]          n_val;

  assign lgn_ok   = (lgn_in != 8'd0) && (lgn_in <= 8'd15);
  assign n_val    = (lgn_q == 8'd0) ? 16'd0 : (16'd1 << lgn_q);
  assign last     = (gen_i_q == (n_val - 16'd1));
  assign counting = (state == EN_HI) || (state == WAIT_RISE) || (state == WAIT_FALL);

`ifdef WINSEQ_TIMEOUT_EN
  assign to_hit = ((state == WAIT_RISE) || (state == WAIT_FALL)) && (cnt == CW'(TIMEOUT - 1));
`else
  assign to_hit = 1'b0;
`endif

  // Q8 coefficient: drop 8 fraction bits, then clamp instead of wrapping
  always_comb begin
    prod = (2*DW)'(s_q) * (2*DW)'(coef);
    shr  = prod >>> 8;
    if (shr > PMAX)      sat = PMAX[DW-1:0];
    else if (shr < PMIN) sat = PMIN[DW-1:0];
    else                 sat = shr[DW-1:0];
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:      if (start && lgn_ok) state_nxt = EN_HI;
        EN_HI:     if (cnt == CW'(EN_HOLD - 1)) state_nxt = WAIT_RISE;
        WAIT_RISE: if (bus.gen_busy) state_nxt = WAIT_FALL;
                   else if (to_hit)  state_nxt = IDLE;
        WAIT_FALL: if (!bus.gen_busy) state_nxt = GET_S;
                   else if (to_hit)   state_nxt = IDLE;
        GET_S:     if (bus.s_valid) state_nxt = MUL;
        MUL:       state_nxt = OUT;
        OUT:       if (bus.m_ready) state_nxt = last ? DONE : EN_HI;
        DONE:      state_nxt = IDLE;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      gen_i_q  <= '0;
      type_q   <= '0;
      lgn_q    <= '0;
      coef     <= '0;
      s_q      <= '0;
      m_data_q <= '0;
      err      <= 1'b0;
    end else begin
      state <= state_nxt;
      // counter restarts on every state entry so each wait gets a full budget
      if (!counting || (state_nxt != state)) cnt <= '0;
      else                                   cnt <= cnt + 1'b1;
      if ((state == IDLE) && start && !abort) begin
        if (lgn_ok) begin
          type_q <= win_type_in;
          lgn_q  <= lgn_in;
          err    <= 1'b0;
        end else begin
          err    <= 1'b1;
        end
      end
      if (to_hit) err <= 1'b1;
      if ((state == WAIT_FALL) && !bus.gen_busy) coef <= bus.gen_win;
      if ((state == GET_S) && bus.s_valid) s_q <= bus.s_data;
      if (state == MUL) m_data_q <= sat;
      if (state_nxt == IDLE)
        gen_i_q <= '0;
      else if ((state == OUT) && bus.m_ready && !last)
        gen_i_q <= gen_i_q + 16'd1;
    end
  end

  assign busy             = (state != IDLE);
  assign frame_done       = (state == DONE);
  assign bus.gen_en       = (state == EN_HI);
  assign bus.s_ready      = (state == GET_S);
  assign bus.m_valid      = (state == OUT);
  assign bus.m_last       = (state == OUT) && last;
  assign bus.m_data       = m_data_q;
  assign bus.gen_win_type = type_q;
  assign bus.gen_lgn      = lgn_q;
  assign bus.gen_n        = n_val;
  assign bus.gen_i        = gen_i_q;

endmodule

// File: tb/tb_window_apply_sequencer.sv
// tb/tb_window_apply_sequencer.sv - scoreboard bench with generator model and randomized frames
module tb_window_apply_sequencer;
  localparam int EN_HOLD = 2;
  localparam int TIMEOUT = 64;
  localparam int DW      = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] win_type_in = '0;
  logic [7:0] lgn_in = '0;
  logic       busy, frame_done, err;

  window_apply_sequencer_if #(.DW(DW)) bus();

  window_apply_sequencer #(.EN_HOLD(EN_HOLD), .TIMEOUT(TIMEOUT), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .win_type_in(win_type_in), .lgn_in(lgn_in),
    .busy(busy), .frame_done(frame_done), .err(err), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int exp_data[$];
  bit exp_last[$];
  int samp_q[$];
  bit gen_dead = 1'b0;
  bit aborting = 1'b0;
  bit bp_pending = 1'b0;
  int done_cnt = 0;

  task automatic check(input string name, input logic signed [63:0] got, input logic signed [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Window shapes the generator model produces, as Q8 (256 = 1.0)
  function automatic int coef_fn(input int typ, input int i, input int n);
    real ph, c;
    int  d;
    ph = 2.0 * 3.14159265358979 * i / n;
    case (typ)
      1: c = 256.0;
      3: begin
        d = 2 * i - n;
        if (d < 0) d = -d;
        c = 256.0 - 256.0 * d / n;
      end
      4: c = 128.0 * (1.0 - $cos(ph));
      5: c = 256.0 * (0.54 - 0.46 * $cos(ph));
      6: c = 256.0 * (0.42 - 0.5 * $cos(ph) + 0.08 * $cos(2.0 * ph));
      default: return ((i * 389 + n * 17) % 2048) - 1024;
    endcase
    return $rtoi(c + 0.5);
  endfunction

  function automatic int model(input int s, input int c);
    longint p;
    p = longint'(s) * longint'(c);
    p = p >>> 8;
    if (p > 32767)  return 32767;
    if (p < -32768) return -32768;
    return int'(p);
  endfunction

  // Generator model: answers each gen_en request with a busy pulse, then the coefficient
  initial begin
    int typ, idx, n, hold;
    bus.gen_busy = 1'b0;
    bus.gen_win  = '0;
    forever begin
      @(negedge clk);
      if (bus.gen_en === 1'b1) begin
        typ  = int'(bus.gen_win_type);
        idx  = int'(bus.gen_i);
        n    = int'(bus.gen_n);
        hold = 0;
        while (bus.gen_en === 1'b1 && hold < 50) begin
          hold++;
          @(negedge clk);
        end
        if (!aborting) check("gen_en_hold", hold, EN_HOLD);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        if (!gen_dead) begin
          bus.gen_busy = 1'b1;
          bus.gen_win  = 16'($urandom);
          repeat ($urandom_range(1, 4)) @(negedge clk);
          bus.gen_win  = 16'(coef_fn(typ, idx, n));
          bus.gen_busy = 1'b0;
        end
      end
    end
  end

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    forever begin
      @(negedge clk);
      if (samp_q.size() > 0 && $urandom_range(0, 3) != 0) begin
        bus.s_valid = 1'b1;
        bus.s_data  = 16'(samp_q[0]);
        if (bus.s_ready === 1'b1) void'(samp_q.pop_front());
      end else begin
        bus.s_valid = 1'b0;
        bus.s_data  = 16'($urandom);
      end
    end
  end

  // Output monitor: pops the scoreboard on each handshake, checks hold under backpressure
  initial begin
    bit   stall_valid;
    logic signed [15:0] stall_data;
    logic stall_last;
    int   bp_left;
    stall_valid = 1'b0;
    stall_data  = '0;
    stall_last  = 1'b0;
    bp_left     = 0;
    bus.m_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (stall_valid && rst_n) begin
        check("m_valid_held", bus.m_valid, 1);
        check("m_data_stable", bus.m_data, stall_data);
        check("m_last_stable", bus.m_last, stall_last);
        check("gen_en_in_stall", bus.gen_en, 0);
      end
      if (bus.m_valid === 1'b1 && bp_pending && bus.gen_i == 16'd1) begin
        bp_left    = 5;
        bp_pending = 1'b0;
      end
      if (bp_left > 0) begin
        bus.m_ready = 1'b0;
        bp_left--;
      end else begin
        bus.m_ready = ($urandom_range(0, 2) != 0);
      end
      stall_valid = 1'b0;
      if (bus.m_valid === 1'b1) begin
        if (bus.m_ready) begin
          if (exp_data.size() == 0) check("unexpected_output", 1, 0);
          else begin
            check("m_data", bus.m_data, exp_data.pop_front());
            check("m_last", bus.m_last, exp_last.pop_front());
          end
        end else begin
          stall_valid = 1'b1;
          stall_data  = bus.m_data;
          stall_last  = bus.m_last;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (frame_done === 1'b1) done_cnt++;
  end

  task automatic load_frame(input int typ, input int lgn, input int mode, input int val);
    int n, s;
    n = 1 << lgn;
    for (int i = 0; i < n; i++) begin
      case (mode)
        0:       s = $urandom_range(0, 65535) - 32768;
        1:       s = val;
        default: s = (i % 2 == 0) ? -32768 : 32767;
      endcase
      samp_q.push_back(s);
      exp_data.push_back(model(s, coef_fn(typ, i, n)));
      exp_last.push_back(i == n - 1);
    end
  endtask

  task automatic pulse_start(input int typ, input int lgn);
    @(negedge clk);
    win_type_in = 4'(typ);
    lgn_in      = 8'(lgn);
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    win_type_in = 4'($urandom);
    lgn_in      = 8'($urandom);
  endtask

  task automatic run_frame(input int typ, input int lgn, input int mode, input int val,
                           input bit bp, input bit restart_mid);
    int d0, cyc;
    load_frame(typ, lgn, mode, val);
    bp_pending = bp;
    d0 = done_cnt;
    pulse_start(typ, lgn);
    check("busy_after_start", busy, 1);
    cyc = 0;
    while (done_cnt == d0 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (restart_mid && cyc == 25) begin
        start  = 1'b1;
        lgn_in = 8'd2;
        @(negedge clk);
        start  = 1'b0;
      end
    end
    if (cyc >= 20000) check("frame_done_wait", 0, 1);
    repeat (3) @(negedge clk);
    check("frame_done_pulses", done_cnt - d0, 1);
    check("scoreboard_drained", exp_data.size(), 0);
    check("idle_after_frame", busy, 0);
    check("err_after_frame", err, 0);
  endtask

  task automatic flush();
    samp_q.delete();
    exp_data.delete();
    exp_last.delete();
  endtask

  task automatic wait_req(input int idx);
    int cyc;
    cyc = 0;
    while (!(bus.gen_en === 1'b1 && bus.gen_i == 16'(idx)) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 5000) check("wait_request", 0, 1);
  endtask

  initial begin
    int types[6] = '{1, 3, 4, 5, 6, 15};
    int d0, cyc;

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_err", err, 0);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_last", bus.m_last, 0);
    check("rst_m_data", bus.m_data, 0);
    check("rst_s_ready", bus.s_ready, 0);
    check("rst_gen_en", bus.gen_en, 0);
    check("rst_gen_i", bus.gen_i, 0);
    check("rst_gen_n", bus.gen_n, 0);
    check("rst_gen_lgn", bus.gen_lgn, 0);
    check("rst_gen_type", bus.gen_win_type, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_frame(1, 2, 1, 1000, 1'b0, 1'b0);
    run_frame(4, 3, 1, 20000, 1'b0, 1'b0);
    run_frame(1, 1, 2, 0, 1'b0, 1'b0);
    run_frame(15, 4, 0, 0, 1'b0, 1'b0);
    run_frame(3, 3, 0, 0, 1'b1, 1'b0);

    pulse_start(4, 0);
    check("illegal_lgn0_err", err, 1);
    check("illegal_lgn0_idle", busy, 0);
    pulse_start(4, 16);
    check("illegal_lgn16_err", err, 1);
    check("illegal_lgn16_idle", busy, 0);

    @(negedge clk);
    start  = 1'b1;
    abort  = 1'b1;
    lgn_in = 8'd3;
    @(negedge clk);
    start  = 1'b0;
    abort  = 1'b0;
    check("start_abort_idle", busy, 0);

    load_frame(5, 3, 0, 0);
    d0 = done_cnt;
    pulse_start(5, 3);
    wait_req(2);
    aborting = 1'b1;
    abort    = 1'b1;
    @(negedge clk);
    abort    = 1'b0;
    flush();
    check("abort_idle", busy, 0);
    check("abort_gen_i", bus.gen_i, 0);
    check("abort_gen_en", bus.gen_en, 0);
    check("abort_m_valid", bus.m_valid, 0);
    repeat (15) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    aborting = 1'b0;
    run_frame(6, 3, 0, 0, 1'b0, 1'b0);

    for (int k = 0; k < 6; k++)
      run_frame(types[$urandom_range(0, 5)], $urandom_range(1, 5), 0, 0,
                1'($urandom_range(0, 1)), 1'(k % 2));

`ifdef WINSEQ_TIMEOUT_EN
    gen_dead = 1'b1;
    aborting = 1'b1;
    d0 = done_cnt;
    pulse_start(1, 2);
    cyc = 0;
    while (busy === 1'b1 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    check("timeout_returns_idle", busy, 0);
    check("timeout_err", err, 1);
    check("timeout_not_early", (cyc >= TIMEOUT) ? 1 : 0, 1);
    check("timeout_no_done", done_cnt - d0, 0);
    repeat (10) @(negedge clk);
    gen_dead = 1'b0;
    aborting = 1'b0;
    run_frame(1, 2, 0, 0, 1'b0, 1'b0);
`endif

    load_frame(4, 4, 0, 0);
    d0 = done_cnt;
    pulse_start(4, 4);
    wait_req(1);
    aborting = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_gen_en", bus.gen_en, 0);
    check("async_rst_gen_i", bus.gen_i, 0);
    check("async_rst_m_valid", bus.m_valid, 0);
    flush();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("async_rst_no_done", done_cnt - d0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
